dsp_add_v3: RTL and testbench

DSP_ADD_V3 -- requirements
Module: dsp_add_v3

---
 rtl/dsp_add_v3.sv | 80 ++++++++
 tb/tb_dsp_add_v3.sv | 125 ++++++++++++
 2 files changed

// File: rtl/dsp_add_v3.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_add_v3
//  Description : Three independent width-bit lane adders, y_i = (a_i + b_i)
//                mod 2^width, mapped onto one DSP slice used in four-lane
//                12-bit SIMD mode with every pipeline register bypassed.
//                Outputs are purely combinational; clock and reset are
//                carried to the slice for port completeness only.
//  Revision    : 1.0  initial release
// ============================================================================
module dsp_add_v3 #(
   parameter int width = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [width-1:0] a0,
   input  logic [width-1:0] b0,
   input  logic [width-1:0] a1,
   input  logic [width-1:0] b1,
   input  logic [width-1:0] a2,
   input  logic [width-1:0] b2,
   output logic [width-1:0] y0,
   output logic [width-1:0] y1,
   output logic [width-1:0] y2
);

   // SIMD geometry of the slice: four 12-bit lanes across a 48-bit path.
   localparam int c_LANE_W = 12;
   localparam int c_LANES  = 4;
   localparam int c_PATH_W = c_LANE_W * c_LANES;

   // Fixed slice configuration: adder only, operands from the A:B and C
   // ports, no pipeline registers anywhere in the path.
   localparam logic [3:0] c_ALUMODE = 4'b0000;   // Z + X + Y
   localparam logic [6:0] c_OPMODE  = 7'b0110011; // X = A:B, Z = C
   localparam logic [3:0] c_REG_EN  = 4'b0000;   // A/B/C/P regs bypassed

   // Slice operand and result buses (lane i at bits [12i+11:12i]).
   logic [c_PATH_W-1:0] w_ab_path;
   logic [c_PATH_W-1:0] w_c_path;
   logic [c_PATH_W-1:0] w_p_path;
   logic [c_LANES-1:0]  w_carry;
   logic                w_unused;

   // Pack the three lanes into the 48-bit operand buses, zero-extended to
   // 12 bits; the fourth lane is tied to zero.
   always_comb begin
      w_ab_path = '0;
      w_c_path  = '0;
      w_ab_path[0*c_LANE_W +: c_LANE_W] = c_LANE_W'(a0);
      w_c_path [0*c_LANE_W +: c_LANE_W] = c_LANE_W'(b0);
      w_ab_path[1*c_LANE_W +: c_LANE_W] = c_LANE_W'(a1);
      w_c_path [1*c_LANE_W +: c_LANE_W] = c_LANE_W'(b1);
      w_ab_path[2*c_LANE_W +: c_LANE_W] = c_LANE_W'(a2);
      w_c_path [2*c_LANE_W +: c_LANE_W] = c_LANE_W'(b2);
   end

   // SIMD ALU: each lane adds on its own 13-bit carry chain so that a
   // carry out of one lane never reaches the next; carries are dropped.
   for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
      logic [c_LANE_W:0] w_sum;
      assign w_sum = {1'b0, w_ab_path[gi*c_LANE_W +: c_LANE_W]}
                   + {1'b0, w_c_path [gi*c_LANE_W +: c_LANE_W]};
      assign w_p_path[gi*c_LANE_W +: c_LANE_W] = w_sum[c_LANE_W-1:0];
      assign w_carry[gi] = w_sum[c_LANE_W];
   end

   // Lane results are the low width bits of each 12-bit SIMD lane; the
   // upper lane bits only ever hold zero-extension carries and are ignored.
   assign y0 = w_p_path[0*c_LANE_W +: width];
   assign y1 = w_p_path[1*c_LANE_W +: width];
   assign y2 = w_p_path[2*c_LANE_W +: width];

   // Clock, reset, the fixed slice controls, discarded carries and the
   // ignored fourth lane have no path to any output.
   assign w_unused = ^{clock, reset, c_ALUMODE, c_OPMODE, c_REG_EN,
                       w_carry, w_p_path};

endmodule
`default_nettype wire

// File: tb/tb_dsp_add_v3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_add_v3
//  Description : Self-checking bench for dsp_add_v3 (width 12 and width 8
//                instances sharing the same stimulus).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dsp_add_v3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] a0, b0, a1, b1, a2, b2;
   logic [11:0] y0, y1, y2;
   logic [7:0]  z0, z1, z2;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clock = ~clock;

   dsp_add_v3 #(.width(12)) u_dut12 (
      .clock(clock), .reset(reset),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .a2(a2), .b2(b2),
      .y0(y0), .y1(y1), .y2(y2)
   );

   dsp_add_v3 #(.width(8)) u_dut8 (
      .clock(clock), .reset(reset),
      .a0(a0[7:0]), .b0(b0[7:0]), .a1(a1[7:0]), .b1(b1[7:0]),
      .a2(a2[7:0]), .b2(b2[7:0]),
      .y0(z0), .y1(z1), .y2(z2)
   );

   task automatic chk(input string tag, input logic [11:0] obs,
                      input logic [11:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%03h want=0x%03h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: modular sum of the operands' low w bits.
   function automatic logic [11:0] ref_sum(input int a, input int b, input int w);
      int m;
      m = 1 << w;
      return 12'(((a % m) + (b % m)) % m);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "/y0"}, y0, ref_sum(int'(a0), int'(b0), 12));
      chk({tag, "/y1"}, y1, ref_sum(int'(a1), int'(b1), 12));
      chk({tag, "/y2"}, y2, ref_sum(int'(a2), int'(b2), 12));
      chk({tag, "/z0"}, {4'h0, z0}, ref_sum(int'(a0), int'(b0), 8));
      chk({tag, "/z1"}, {4'h0, z1}, ref_sum(int'(a1), int'(b1), 8));
      chk({tag, "/z2"}, {4'h0, z2}, ref_sum(int'(a2), int'(b2), 8));
   endtask

   initial begin
      // Signed-operand vector held from time 0 with reset asserted.
      a0 = 12'h001; b0 = 12'hFF0;
      a1 = 12'hFE9; b1 = 12'hFF9;
      a2 = 12'd25;  b2 = 12'd7;
      #1;
      chk("inreset_y0", y0, 12'hFF1);
      chk("inreset_y1", y1, 12'hFE2);
      @(negedge clock) reset = 1'b0;
      @(posedge clock) #1;
      chk("first_y0", y0, 12'hFF1);
      chk("first_y1", y1, 12'hFE2);
      chk("first_y2", y2, 12'h020);
      check_all("first");

      // Lane isolation: full-scale carries must not leak.
      @(negedge clock);
      a0 = 12'hFFF; b0 = 12'h001;
      a1 = 12'h000; b1 = 12'h000;
      a2 = 12'hFFF; b2 = 12'hFFF;
      #1;
      chk("iso_y0", y0, 12'h000);
      chk("iso_y1", y1, 12'h000);
      chk("iso_y2", y2, 12'hFFE);

      // Zero latency: mid-cycle change visible before the next edge.
      @(negedge clock);
      a1 = 12'd23; b1 = 12'd7;
      #1 chk("lat_before", y1, 12'd30);
      #1 a1 = 12'd24;
      #1 chk("lat_after", y1, 12'd31);

      // Reset held high has no effect on outputs.
      @(negedge clock);
      reset = 1'b1; a0 = 12'd5; b0 = 12'd6;
      #1 chk("rst_hi_y0", y0, 12'd11);
      @(posedge clock) #1 chk("rst_hi_edge_y0", y0, 12'd11);
      @(negedge clock) reset = 1'b0;
      @(posedge clock) #1 chk("rst_lo_y0", y0, 12'd11);

      // Width 8 instance: wraparound and no leakage into lane 2.
      @(negedge clock);
      a0 = 12'h0FF; b0 = 12'h010;
      a1 = 12'h080; b1 = 12'h080;
      a2 = 12'h000; b2 = 12'h000;
      #1;
      chk("w8_z0", {4'h0, z0}, 12'h00F);
      chk("w8_z1", {4'h0, z1}, 12'h000);
      chk("w8_z2", {4'h0, z2}, 12'h000);
      chk("w8_y1", y1, 12'h100);

      // Randomized vectors, reset toggled occasionally.
      for (int i = 0; i < 1000; i++) begin
         @(negedge clock);
         a0 = 12'($urandom_range(0, 4095)); b0 = 12'($urandom_range(0, 4095));
         a1 = 12'($urandom_range(0, 4095)); b1 = 12'($urandom_range(0, 4095));
         a2 = 12'($urandom_range(0, 4095)); b2 = 12'($urandom_range(0, 4095));
         reset = ($urandom_range(0, 15) == 0);
         #1 check_all("rnd");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
